// File: rtl/block_xfer_seq.sv
// Load/store-multiple sequencer: walks a 16-bit register list in ascending order and
// moves one word per set bit between the register file and a req/ack memory port.
module block_xfer_seq #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              is_load_i,
    input  logic [15:0]       reg_list_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] wb_addr_o,
    output logic [3:0]        rf_rA_o,
    input  logic [DATA_W-1:0] rf_rD_i,
    output logic              rf_wEn_o,
    output logic [3:0]        rf_wA_o,
    output logic [DATA_W-1:0] rf_wD_o,
    output logic              pc_wEn_o,
    output logic [DATA_W-1:0] pc_wD_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_REQ,
        S_WB,
        S_FIN
    } state_t;

    state_t            state_q;
    logic              is_load_q;
    logic [15:0]       rem_q;
    logic [ADDR_W-1:0] cur_addr_q;
    logic              busy_q;
    logic              done_q;
    logic [ADDR_W-1:0] wb_addr_q;
    logic [3:0]        rf_ra_q;
    logic              rf_wen_q;
    logic [3:0]        rf_wa_q;
    logic [DATA_W-1:0] rf_wd_q;
    logic              pc_wen_q;
    logic [DATA_W-1:0] pc_wd_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    logic [15:0]       rem_clr_d;
    logic [ADDR_W-1:0] wb_addr_d;

    // Index of the lowest set bit (priority encoder, bit 0 highest priority).
    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    // Number of set bits in the register list.
    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] cnt;
        cnt = 5'd0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + 5'(v[i]);
        end
        return cnt;
    endfunction

    // Remaining list with the in-flight register retired, and the final base address.
    always_comb begin
        rem_clr_d = rem_q & ~(16'(1) << rf_ra_q);
        wb_addr_d = base_addr_i + ADDR_W'({popcount16(reg_list_i), 2'b00});
    end

    // Sequencer FSM; rf_rA is pre-loaded on entry to SCAN so rf_rD is valid during SCAN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            is_load_q   <= 1'b0;
            rem_q       <= '0;
            cur_addr_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wb_addr_q   <= '0;
            rf_ra_q     <= '0;
            rf_wen_q    <= 1'b0;
            rf_wa_q     <= '0;
            rf_wd_q     <= '0;
            pc_wen_q    <= 1'b0;
            pc_wd_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            done_q   <= 1'b0;
            rf_wen_q <= 1'b0;
            pc_wen_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        is_load_q  <= is_load_i;
                        rem_q      <= reg_list_i;
                        cur_addr_q <= base_addr_i;
                        wb_addr_q  <= wb_addr_d;
                        busy_q     <= 1'b1;
                        if (reg_list_i != '0) rf_ra_q <= lowest_set(reg_list_i);
                        state_q    <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (rem_q == '0) begin
                        done_q  <= 1'b1;
                        state_q <= S_FIN;
                    end else begin
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= !is_load_q;
                        mem_addr_q <= {cur_addr_q[ADDR_W-1:2], 2'b00};
                        if (!is_load_q) mem_wdata_q <= rf_rD_i;
                        state_q    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_ack_i) begin
                        mem_req_q  <= 1'b0;
                        rem_q      <= rem_clr_d;
                        cur_addr_q <= cur_addr_q + ADDR_W'(4);
                        if (is_load_q) begin
                            // r15 goes through the dedicated PC path, never the write port.
                            if (rf_ra_q == 4'd15) begin
                                pc_wen_q <= 1'b1;
                                pc_wd_q  <= mem_rdata_i;
                            end else begin
                                rf_wen_q <= 1'b1;
                                rf_wa_q  <= rf_ra_q;
                                rf_wd_q  <= mem_rdata_i;
                            end
                            state_q <= S_WB;
                        end else begin
                            if (rem_clr_d != '0) rf_ra_q <= lowest_set(rem_clr_d);
                            state_q <= S_SCAN;
                        end
                    end
                end
                S_WB: begin
                    if (rem_q != '0) rf_ra_q <= lowest_set(rem_q);
                    state_q <= S_SCAN;
                end
                S_FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign wb_addr_o   = wb_addr_q;
    assign rf_rA_o     = rf_ra_q;
    assign rf_wEn_o    = rf_wen_q;
    assign rf_wA_o     = rf_wa_q;
    assign rf_wD_o     = rf_wd_q;
    assign pc_wEn_o    = pc_wen_q;
    assign pc_wD_o     = pc_wd_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_block_xfer_seq.sv
// Scoreboard bench for block_xfer_seq: memory and writeback expectations are queued at start.
module tb_block_xfer_seq;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              is_load;
    logic [15:0]       reg_list;
    logic [ADDR_W-1:0] base_addr;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] wb_addr;
    logic [3:0]        rf_rA;
    logic [DATA_W-1:0] rf_rD;
    logic              rf_wEn;
    logic [3:0]        rf_wA;
    logic [DATA_W-1:0] rf_wD;
    logic              pc_wEn;
    logic [DATA_W-1:0] pc_wD;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } mem_item_t;

    typedef struct packed {
        logic        is_pc;
        logic [3:0]  idx;
        logic [31:0] data;
    } wr_item_t;

    mem_item_t   mem_q[$];
    wr_item_t    wr_q[$];
    logic [31:0] wb_q[$];
    logic [31:0] regs [16];
    int          n_tests;
    int          n_fail;
    int          ack_delay;

    block_xfer_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start),
        .is_load_i   (is_load),
        .reg_list_i  (reg_list),
        .base_addr_i (base_addr),
        .busy_o      (busy),
        .done_o      (done),
        .wb_addr_o   (wb_addr),
        .rf_rA_o     (rf_rA),
        .rf_rD_i     (rf_rD),
        .rf_wEn_o    (rf_wEn),
        .rf_wA_o     (rf_wA),
        .rf_wD_o     (rf_wD),
        .pc_wEn_o    (pc_wEn),
        .pc_wD_o     (pc_wD),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_ack_i   (mem_ack),
        .mem_rdata_i (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational register file read port.
    assign rf_rD = regs[rf_rA];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_busy"},      64'(busy),      64'd0);
        check_eq({tag, "_done"},      64'(done),      64'd0);
        check_eq({tag, "_wb_addr"},   64'(wb_addr),   64'd0);
        check_eq({tag, "_rf_rA"},     64'(rf_rA),     64'd0);
        check_eq({tag, "_rf_wEn"},    64'(rf_wEn),    64'd0);
        check_eq({tag, "_rf_wA"},     64'(rf_wA),     64'd0);
        check_eq({tag, "_rf_wD"},     64'(rf_wD),     64'd0);
        check_eq({tag, "_pc_wEn"},    64'(pc_wEn),    64'd0);
        check_eq({tag, "_pc_wD"},     64'(pc_wD),     64'd0);
        check_eq({tag, "_mem_req"},   64'(mem_req),   64'd0);
        check_eq({tag, "_mem_we"},    64'(mem_we),    64'd0);
        check_eq({tag, "_mem_addr"},  64'(mem_addr),  64'd0);
        check_eq({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    endtask

    // Memory responder: acks after ack_delay wait cycles and checks each request.
    initial begin
        int          cnt;
        logic [31:0] a0;
        logic [31:0] d0;
        logic        stable;
        mem_item_t   it;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        cnt       = 0;
        stable    = 1'b1;
        a0        = '0;
        d0        = '0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (!rst_n || !mem_req) begin
                cnt = 0;
            end else begin
                if (cnt == 0) begin
                    a0     = mem_addr;
                    d0     = mem_wdata;
                    stable = 1'b1;
                end else if (mem_addr !== a0 || mem_wdata !== d0) begin
                    stable = 1'b0;
                end
                if (cnt == ack_delay) begin
                    check_eq("req_stable", 64'(stable), 64'd1);
                    if (mem_q.size() == 0) begin
                        check_eq("mem_unexpected", 64'(mem_q.size()), 64'd1);
                    end else begin
                        it = mem_q.pop_front();
                        check_eq("mem_we", 64'(mem_we), 64'(it.we));
                        check_eq("mem_addr", 64'(mem_addr), 64'(it.addr));
                        if (it.we) check_eq("mem_wdata", 64'(mem_wdata), 64'(it.wdata));
                        mem_rdata = it.rdata;
                    end
                    mem_ack = 1'b1;
                    cnt     = 0;
                end else begin
                    cnt++;
                end
            end
        end
    end

    // Writeback monitor: every rf/pc write must match the next queued expectation.
    initial begin
        wr_item_t wi;
        forever begin
            @(negedge clk);
            if (rst_n && (rf_wEn || pc_wEn)) begin
                check_eq("wen_excl", 64'(rf_wEn & pc_wEn), 64'd0);
                if (wr_q.size() == 0) begin
                    check_eq("wr_unexpected", 64'(wr_q.size()), 64'd1);
                end else begin
                    wi = wr_q.pop_front();
                    check_eq("wr_is_pc", 64'(pc_wEn), 64'(wi.is_pc));
                    if (wi.is_pc) begin
                        check_eq("pc_wD", 64'(pc_wD), 64'(wi.data));
                    end else begin
                        check_eq("rf_wA", 64'(rf_wA), 64'(wi.idx));
                        check_eq("rf_wD", 64'(rf_wD), 64'(wi.data));
                    end
                end
            end
        end
    end

    // Completion monitor: wb_addr on each done pulse.
    initial begin
        logic [31:0] exp_wb;
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                check_eq("done_busy", 64'(busy), 64'd1);
                if (wb_q.size() == 0) begin
                    check_eq("done_unexpected", 64'(wb_q.size()), 64'd1);
                end else begin
                    exp_wb = wb_q.pop_front();
                    check_eq("wb_addr", 64'(wb_addr), 64'(exp_wb));
                end
            end
        end
    end

    // Queue expectations, pulse start, and time the transfer to done.
    task automatic run_xfer(input logic ld, input logic [15:0] list, input logic [31:0] base,
                            input int delay, input logic [15:0] glitch);
        int        k;
        int        lat;
        int        exp_lat;
        mem_item_t mi;
        wr_item_t  wi;
        ack_delay = delay;
        k = 0;
        for (int i = 0; i < 16; i++) begin
            if (list[i]) begin
                mi.we    = !ld;
                mi.addr  = base + 32'(4 * k);
                mi.wdata = regs[i];
                mi.rdata = 32'hAAAA0000 + 32'(k) * 32'h11110000 + 32'(i);
                mem_q.push_back(mi);
                if (ld) begin
                    wi.is_pc = (i == 15);
                    wi.idx   = 4'(i);
                    wi.data  = mi.rdata;
                    wr_q.push_back(wi);
                end
                k++;
            end
        end
        wb_q.push_back(base + 32'(4 * k));
        exp_lat = (k == 0) ? 2 : k * ((ld ? 3 : 2) + delay) + 2;

        @(negedge clk);
        start     = 1'b1;
        is_load   = ld;
        reg_list  = list;
        base_addr = base;
        @(negedge clk);
        start     = 1'b0;
        is_load   = !ld;
        reg_list  = (glitch != 16'd0) ? glitch : ~list;
        base_addr = ~base;
        lat = 1;
        while (!done && lat < 400) begin
            start = (glitch != 16'd0) && (lat == 3);
            @(negedge clk);
            lat++;
        end
        check_eq("latency", 64'(lat), 64'(exp_lat));
        // A start during the done cycle must also be ignored.
        start = (glitch != 16'd0);
        @(negedge clk);
        start = 1'b0;
        check_eq("busy_after", 64'(busy), 64'd0);
        check_eq("req_after", 64'(mem_req), 64'd0);
        check_eq("mem_q_empty", 64'(mem_q.size()), 64'd0);
        check_eq("wr_q_empty", 64'(wr_q.size()), 64'd0);
        check_eq("wb_q_empty", 64'(wb_q.size()), 64'd0);
    endtask

    initial begin
        int i;
        n_tests   = 0;
        n_fail    = 0;
        ack_delay = 0;
        start     = 1'b0;
        is_load   = 1'b0;
        reg_list  = '0;
        base_addr = '0;
        for (int r = 0; r < 16; r++) regs[r] = 32'hC0DE0000 + 32'(r) * 32'h0101;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run_xfer(1'b0, 16'h0005, 32'h0000_0100, 0, 16'h0000);
        run_xfer(1'b1, 16'h8002, 32'h0000_0200, 0, 16'h0000);
        run_xfer(1'b0, 16'h0000, 32'h0000_0300, 0, 16'h0000);
        run_xfer(1'b0, 16'h0001, 32'h0000_0400, 3, 16'h0000);
        run_xfer(1'b0, 16'h00F0, 32'h0000_0500, 1, 16'h0F0F);
        run_xfer(1'b1, 16'hFFFF, 32'h0000_1000, 2, 16'h0000);
        run_xfer(1'b0, 16'hC001, 32'hFFFF_FFF8, 0, 16'h0000);
        run_xfer(1'b1, 16'h0000, 32'h0000_0700, 0, 16'h0000);

        // Reset in the middle of a load request aborts with all outputs cleared.
        ack_delay = 5;
        @(negedge clk);
        start     = 1'b1;
        is_load   = 1'b1;
        reg_list  = 16'h0003;
        base_addr = 32'h0000_0600;
        @(negedge clk);
        start = 1'b0;
        i = 0;
        while (!mem_req && i < 10) begin
            @(negedge clk);
            i++;
        end
        check_eq("abort_req_seen", 64'(mem_req), 64'd1);
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("abort");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check_eq("abort_idle_busy", 64'(busy), 64'd0);
        run_xfer(1'b1, 16'h0003, 32'h0000_0600, 1, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
